// File: rtl/trigger_serial_pattern.sv
// rtl/trigger_serial_pattern.sv - 8N1 serial byte-pattern trigger generator
//
// Watches one target IO line, decodes 8N1 frames at a programmable bit
// period and raises a one-cycle trigger when the newest received bytes match
// a masked pattern of 1-8 bytes.
//
// Ports:
//   clk            system and register clock, rising edge
//   reset_n        asynchronous active-low reset
//   reg_address    register address (41 CFG, 42 PATTERN, 43 STATUS)
//   reg_bytecnt    byte index within a multi-byte register
//   reg_datai      write data
//   reg_datao      registered read data, 0 when not selected
//   reg_read       read strobe
//   reg_write      write strobe
//   reg_addrvalid  address-valid flag
//   reg_hypaddress address for the register length query
//   reg_hyplen     combinational register length for reg_hypaddress
//   io_line_i      asynchronous serial input from the target
//   trigger_o      registered one-cycle match pulse

module trigger_serial_pattern #(
    parameter int DIV_RESET = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  reg_address,
    input  logic [15:0] reg_bytecnt,
    input  logic [7:0]  reg_datai,
    output logic [7:0]  reg_datao,
    input  logic        reg_read,
    input  logic        reg_write,
    input  logic        reg_addrvalid,
    input  logic [5:0]  reg_hypaddress,
    output logic [15:0] reg_hyplen,
    input  logic        io_line_i,
    output logic        trigger_o
);

    localparam logic [5:0] ADDR_CFG    = 6'd41;
    localparam logic [5:0] ADDR_PAT    = 6'd42;
    localparam logic [5:0] ADDR_STATUS = 6'd43;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_t;

    // Configuration and status storage
    logic [15:0] div_q;
    logic [7:0]  len_q;
    logic [7:0]  ctl_q;
    logic [7:0]  pat_q [16];
    logic [7:0]  err_q;

    // Receiver state
    rx_state_t   state;
    logic [15:0] cnt;
    logic [2:0]  bitn;
    logic [7:0]  shreg;
    logic        armed;
    logic [7:0]  hist [8];
    logic [3:0]  hcnt;

    logic        sync1, sync2, s;
    logic        wr_en, cfg_wr, stat_clr;
    logic        en, inv;
    logic [15:0] n_eff, n_m1, half_m1;
    logic [3:0]  l_eff, hcnt_next;
    logic        stop_tick;
    logic        match;
    logic [7:0]  new_h [8];
    logic [3:0]  idx;
    logic [7:0]  rd_byte;

    // Read data depends only on the address, so the read strobe carries no
    // information for this block.
    logic unused_read;
    assign unused_read = reg_read;

    assign wr_en    = reg_write & reg_addrvalid;
    assign cfg_wr   = wr_en && (reg_address == ADDR_CFG) && (reg_bytecnt < 16'd4);
    assign stat_clr = wr_en && (reg_address == ADDR_STATUS) && (reg_bytecnt == 16'd0);

    assign en  = ctl_q[0];
    assign inv = ctl_q[1];

    assign n_eff   = (div_q < 16'd4) ? 16'd4 : div_q;
    assign n_m1    = n_eff - 16'd1;
    assign half_m1 = (n_eff >> 1) - 16'd1;

    assign l_eff     = (len_q[3:0] == 4'd0) ? 4'd1 :
                       (len_q[3:0] > 4'd8)  ? 4'd8 : len_q[3:0];
    assign hcnt_next = (hcnt == 4'd8) ? 4'd8 : hcnt + 4'd1;

    assign s = sync2 ^ inv;

    // Stop-bit sample cycle; shared by the FSM and the error counter so both
    // see exactly the same decision.
    assign stop_tick = en && !cfg_wr && (state == ST_STOP) && (cnt == n_m1);

    always_comb begin
        reg_hyplen = 16'd0;
        case (reg_hypaddress)
            ADDR_CFG:    reg_hyplen = 16'd4;
            ADDR_PAT:    reg_hyplen = 16'd16;
            ADDR_STATUS: reg_hyplen = 16'd1;
            default:     reg_hyplen = 16'd0;
        endcase
    end

    // Compare against the history as it will be after this push: H0 is the
    // byte just received, and P[0] lines up with the oldest byte of the window.
    always_comb begin
        new_h[0] = shreg;
        for (int i = 1; i < 8; i++) begin
            new_h[i] = hist[i-1];
        end
        idx   = 4'd0;
        match = (hcnt_next >= l_eff);
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < l_eff) begin
                idx = l_eff - 4'(k) - 4'd1;
                if (((new_h[idx[2:0]] ^ pat_q[k]) & pat_q[k+8]) != 8'h00) begin
                    match = 1'b0;
                end
            end
        end
    end

    always_comb begin
        rd_byte = 8'h00;
        case (reg_address)
            ADDR_CFG: begin
                case (reg_bytecnt)
                    16'd0:   rd_byte = div_q[7:0];
                    16'd1:   rd_byte = div_q[15:8];
                    16'd2:   rd_byte = len_q;
                    16'd3:   rd_byte = ctl_q;
                    default: rd_byte = 8'h00;
                endcase
            end
            ADDR_PAT: begin
                if (reg_bytecnt < 16'd16) begin
                    rd_byte = pat_q[reg_bytecnt[3:0]];
                end
            end
            ADDR_STATUS: begin
                if (reg_bytecnt == 16'd0) begin
                    rd_byte = err_q;
                end
            end
            default: rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_datao <= 8'h00;
        end else begin
            reg_datao <= reg_addrvalid ? rd_byte : 8'h00;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= 16'(DIV_RESET);
            len_q <= 8'h01;
            ctl_q <= 8'h00;
            for (int k = 0; k < 16; k++) begin
                pat_q[k] <= 8'h00;
            end
        end else if (wr_en) begin
            if (reg_address == ADDR_CFG) begin
                case (reg_bytecnt)
                    16'd0:   div_q[7:0]  <= reg_datai;
                    16'd1:   div_q[15:8] <= reg_datai;
                    16'd2:   len_q       <= reg_datai;
                    16'd3:   ctl_q       <= reg_datai;
                    default: ;
                endcase
            end else if ((reg_address == ADDR_PAT) && (reg_bytecnt < 16'd16)) begin
                pat_q[reg_bytecnt[3:0]] <= reg_datai;
            end
        end
    end

    // Synchronizer resets to the idle level so no false start bit is seen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= io_line_i;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 8'h00;
        end else if (stat_clr) begin
            err_q <= 8'h00;
        end else if (stop_tick && !s && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'h01;
        end
    end

    // Receiver. `armed` means the line has been seen idle since the last
    // framing error or abort, so a low level is a genuine start bit.
    // cnt counts cycles since the start-bit detection cycle (that cycle is 0),
    // so the start-bit centre is at cnt == N/2-1 and each later sample is N
    // cycles after the previous one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cnt       <= 16'd0;
            bitn      <= 3'd0;
            shreg     <= 8'h00;
            armed     <= 1'b0;
            hcnt      <= 4'd0;
            trigger_o <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                hist[i] <= 8'h00;
            end
        end else if (!en) begin
            state     <= ST_IDLE;
            cnt       <= 16'd0;
            bitn      <= 3'd0;
            armed     <= 1'b0;
            hcnt      <= 4'd0;
            trigger_o <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                hist[i] <= 8'h00;
            end
        end else begin
            trigger_o <= 1'b0;
            if (cfg_wr) begin
                state <= ST_IDLE;
                armed <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (!armed) begin
                            if (s) begin
                                armed <= 1'b1;
                            end
                        end else if (!s) begin
                            state <= ST_START;
                            cnt   <= 16'd1;
                        end
                    end
                    ST_START: begin
                        if (cnt == half_m1) begin
                            cnt  <= 16'd0;
                            bitn <= 3'd0;
                            state <= s ? ST_IDLE : ST_DATA;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    ST_DATA: begin
                        if (cnt == n_m1) begin
                            cnt   <= 16'd0;
                            shreg <= {s, shreg[7:1]};
                            bitn  <= bitn + 3'd1;
                            if (bitn == 3'd7) begin
                                state <= ST_STOP;
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    ST_STOP: begin
                        if (cnt == n_m1) begin
                            cnt   <= 16'd0;
                            state <= ST_IDLE;
                            if (s) begin
                                armed <= 1'b1;
                                for (int i = 0; i < 8; i++) begin
                                    hist[i] <= new_h[i];
                                end
                                hcnt      <= hcnt_next;
                                trigger_o <= match;
                            end else begin
                                armed <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
